// File: rtl/vm_register_pkg.sv
// Shared vending-machine constants used by the datapath storage blocks.
package vm_register_pkg;

  // Data width of every vending-machine datapath word (credit, price, change).
  localparam int VM_DATA_W = 8;

endpackage : vm_register_pkg

// File: rtl/vm_register.sv
// vm_register: parameterised datapath register with synchronous clear and
// load enable. Clear has priority over load; otherwise the value holds.
// The output is driven straight from the flops, so no input reaches data_o
// without passing through a clock edge.
module vm_register
  import vm_register_pkg::*;
#(
  parameter int               WIDTH     = VM_DATA_W,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  // Stored value. The declaration initialiser sets the configuration value,
  // so the register reads RESET_VAL before any clear has been applied.
  logic [WIDTH-1:0] data_r = RESET_VAL;

  // Clear beats load; with neither asserted the stored value is held.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      data_r <= RESET_VAL;
    end else if (ld_i) begin
      data_r <= data_i;
    end else begin
      data_r <= data_r;
    end
  end

  assign data_o = data_r;

endmodule : vm_register

// File: tb/tb_vm_register.sv
// Directed self-checking bench for vm_register: a default 8-bit instance and
// a 12-bit instance with a non-zero clear value.
module tb_vm_register;

  logic        clk;
  // Default instance (WIDTH = 8, RESET_VAL = 0)
  logic        clr_a;
  logic        ld_a;
  logic [7:0]  din_a;
  logic [7:0]  dout_a;
  // Wide instance (WIDTH = 12, RESET_VAL = 12'h5A5)
  logic        clr_b;
  logic        ld_b;
  logic [11:0] din_b;
  logic [11:0] dout_b;

  int checks = 0;
  int errors = 0;

  vm_register u_dut_a (
    .clk_i  (clk),
    .clr_i  (clr_a),
    .ld_i   (ld_a),
    .data_i (din_a),
    .data_o (dout_a)
  );

  vm_register #(
    .WIDTH     (12),
    .RESET_VAL (12'h5A5)
  ) u_dut_b (
    .clk_i  (clk),
    .clr_i  (clr_b),
    .ld_i   (ld_b),
    .data_i (din_b),
    .data_o (dout_b)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and count it.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive default-instance inputs on the falling edge, then wait for the
  // next rising edge and settle 1 time unit past it.
  task automatic step_a(input logic clr, input logic ld, input logic [7:0] d);
    @(negedge clk);
    clr_a = clr;
    ld_a  = ld;
    din_a = d;
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input logic clr, input logic ld, input logic [11:0] d);
    @(negedge clk);
    clr_b = clr;
    ld_b  = ld;
    din_b = d;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] b2b_data [3];

  initial begin
    clr_a = 1'b0; ld_a = 1'b0; din_a = 8'd0;
    clr_b = 1'b0; ld_b = 1'b0; din_b = 12'd0;

    // Power-up: configuration values before any edge
    #1;
    check("powerup_a", 32'(dout_a), 32'h0);
    check("powerup_b", 32'(dout_b), 32'h5A5);

    // Load 16
    step_a(1'b0, 1'b1, 8'd16);
    check("load_16", 32'(dout_a), 32'd16);

    // Hold: data_i changes to 28 with ld_i low; checked mid-cycle as well
    @(negedge clk);
    ld_a  = 1'b0;
    din_a = 8'd28;
    #1;
    check("no_comb_path", 32'(dout_a), 32'd16);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold_%0d", i), 32'(dout_a), 32'd16);
    end

    // Clear, then stays 0 for 3 edges with ld_i low
    step_a(1'b1, 1'b0, 8'd28);
    check("clear", 32'(dout_a), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step_a(1'b0, 1'b0, 8'd28);
      check($sformatf("post_clear_hold_%0d", i), 32'(dout_a), 32'd0);
    end

    // Priority: load a nonzero value first so the clear is observable
    step_a(1'b0, 1'b1, 8'h55);
    check("preload_55", 32'(dout_a), 32'h55);
    step_a(1'b1, 1'b1, 8'hAA);
    check("clr_over_ld", 32'(dout_a), 32'd0);

    // Back-to-back loads with ld_i held high
    b2b_data[0] = 8'd1;
    b2b_data[1] = 8'd2;
    b2b_data[2] = 8'd255;
    for (int i = 0; i < 3; i++) begin
      step_a(1'b0, 1'b1, b2b_data[i]);
      check($sformatf("b2b_%0d", i), 32'(dout_a), 32'(b2b_data[i]));
    end

    // Clear mid-stream with ld_i still high, then loading resumes
    step_a(1'b1, 1'b1, 8'h3C);
    check("midstream_clear", 32'(dout_a), 32'd0);
    step_a(1'b0, 1'b1, 8'h3C);
    check("resume_load", 32'(dout_a), 32'h3C);
    step_a(1'b0, 1'b0, 8'hC3);
    check("resume_hold", 32'(dout_a), 32'h3C);

    // Wide instance: full-width load, then clear to the non-zero reset value
    check("wide_idle", 32'(dout_b), 32'h5A5);
    step_b(1'b0, 1'b1, 12'hFFF);
    check("wide_load_fff", 32'(dout_b), 32'hFFF);
    step_b(1'b1, 1'b0, 12'h000);
    check("wide_clear", 32'(dout_b), 32'h5A5);
    step_b(1'b1, 1'b1, 12'h123);
    check("wide_clr_over_ld", 32'(dout_b), 32'h5A5);
    step_b(1'b0, 1'b1, 12'h800);
    check("wide_load_msb", 32'(dout_b), 32'h800);

    // Default instance was idle throughout the wide-instance steps
    check("a_unaffected", 32'(dout_a), 32'h3C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_vm_register
